// File: rtl/tc_pl_bus_pkg.sv
// Shared definitions for the PL bus SPI transmit path.
// Contents:
//   spi_state_e  - serializer FSM state encoding (IDLE / SHIFT)
//   SPI_CPOL     - SCLK idle level (mode 0: low)
//   SPI_CPHA     - clock phase (mode 0: data launched on the falling edge
//                  and captured on the rising edge)
package tc_pl_bus_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_e;

    localparam logic SPI_CPOL = 1'b0;
    localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/tc_pl_bus_spi_clkgen.sv
// SCLK generator for the SPI serializer.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   run      in   1 while a byte is being shifted; 0 parks SCLK at idle level
//   sclk     out  registered SPI clock
//   rise_stb out  one-cycle strobe, high in the cycle whose clock edge
//                 drives sclk from low to high
//   fall_stb out  one-cycle strobe, high in the cycle whose clock edge
//                 drives sclk from high to low
// The divider counts 0..CLK_DIV-1 and toggles sclk at the terminal count,
// so one SCLK half-period is CLK_DIV system clocks.
module tc_pl_bus_spi_clkgen
    import tc_pl_bus_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sclk,
    output logic rise_stb,
    output logic fall_stb
);

    localparam int DW = ($clog2(CLK_DIV) > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] TERM = DW'(CLK_DIV - 1);

    logic [DW-1:0] cnt_q;
    logic          sclk_q;
    logic          term_hit;

    assign term_hit = run && (cnt_q == TERM);

    // Strobes are combinational so the parent acts on the same clock edge
    // that toggles sclk.
    assign rise_stb = term_hit && (sclk_q == SPI_CPOL);
    assign fall_stb = term_hit && (sclk_q != SPI_CPOL);
    assign sclk     = sclk_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else if (!run) begin
            cnt_q  <= '0;
            sclk_q <= SPI_CPOL;
        end else if (term_hit) begin
            cnt_q  <= '0;
            sclk_q <= ~sclk_q;
        end else begin
            cnt_q  <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/tc_pl_bus_spi_tx.sv
// SPI mode-0 master serializer fed by the PL bus transmitter.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   spit_valid in   upstream byte valid
//   spit_data  in   upstream byte (SPI0_0 bits)
//   spit_dreq  out  ready; a byte transfers on a cycle with valid && dreq
//   spit_idle  out  nothing buffered and nothing shifting
//   spi_sclk   out  SPI clock, idles low
//   spi_mosi   out  serial data, MSB first
// Handshake: a byte moves on every clock edge where spit_valid and
// spit_dreq are both high; spit_valid seen while spit_dreq is low is
// ignored and upstream must hold the byte. One byte is buffered in a
// holding register ahead of the shift register, which lets the next byte
// start on the final falling SCLK edge of the current one with no gap.
module tc_pl_bus_spi_tx
    import tc_pl_bus_pkg::*;
#(
    parameter int SPI0_0  = 8,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spit_valid,
    input  logic [SPI0_0-1:0] spit_data,
    output logic              spit_dreq,
    output logic              spit_idle,
    output logic              spi_sclk,
    output logic              spi_mosi
);

    localparam int BCW = $clog2(SPI0_0 + 1);
    localparam logic [BCW-1:0] BITS = BCW'(SPI0_0);

    spi_state_e        state_q, state_d;
    logic [SPI0_0-1:0] hold_q, hold_d;
    logic              hold_full_q, hold_full_d;
    logic [SPI0_0-1:0] shift_q, shift_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;
    logic              mosi_q, mosi_d;
    logic              dreq_q, dreq_d;
    logic              idle_q, idle_d;

    logic run, rise_stb, fall_stb;
    logic launch_stb, capture_stb;
    logic accept, load, byte_done;

    assign run = (state_q == ST_SHIFT);

    tc_pl_bus_spi_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .sclk     (spi_sclk),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );

    // Mode 0 launches data on the falling edge and captures on the rising one.
    assign launch_stb  = (SPI_CPHA == 1'b0) ? fall_stb : rise_stb;
    assign capture_stb = (SPI_CPHA == 1'b0) ? rise_stb : fall_stb;

    assign accept    = spit_valid && dreq_q;
    // The bit counter reaches zero after the last capture edge, so the
    // next launch edge is the end of the byte.
    assign byte_done = launch_stb && (bit_cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        mosi_d      = mosi_q;
        load        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (capture_stb) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
                if (byte_done) begin
                    if (hold_full_q) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        mosi_d  = 1'b0;
                    end
                end else if (launch_stb) begin
                    shift_d = shift_q << 1;
                    mosi_d  = shift_q[SPI0_0-2];
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            shift_d     = hold_q;
            mosi_d      = hold_q[SPI0_0-1];
            bit_cnt_d   = BITS;
            hold_full_d = 1'b0;
        end

        // An accept in the same cycle as a reload refills the freed slot.
        if (accept) begin
            hold_d      = spit_data;
            hold_full_d = 1'b1;
        end

        dreq_d = !hold_full_d;
        idle_d = (state_d == ST_IDLE) && !hold_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            mosi_q      <= 1'b0;
            dreq_q      <= 1'b0;
            idle_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            mosi_q      <= mosi_d;
            dreq_q      <= dreq_d;
            idle_q      <= idle_d;
        end
    end

    assign spit_dreq = dreq_q;
    assign spit_idle = idle_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_tc_pl_bus_spi_tx.sv
// Bench for tc_pl_bus_spi_tx: one instance at default parameters and one
// at CLK_DIV=1 / SPI0_0=16. Monitors record every SCLK rising edge (cycle
// number and MOSI value); the expected byte stream and edge timing come
// from the transmit rules (MSB first, 2*CLK_DIV cycles per bit).
module tb_tc_pl_bus_spi_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       spit_valid = 1'b0;
    logic [7:0] spit_data = '0;
    logic       spit_dreq, spit_idle, spi_sclk, spi_mosi;

    logic        v2 = 1'b0;
    logic [15:0] d2 = '0;
    logic        dreq2, idle2, sclk2, mosi2;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    logic       got_bits[$];
    int         rise_q[$];
    logic [7:0] exp_q[$];
    logic       got2_bits[$];
    int         rise2_q[$];
    logic       prev_sclk = 1'b0;
    logic       prev_sclk2 = 1'b0;

    tc_pl_bus_spi_tx #(.SPI0_0(8), .CLK_DIV(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .spit_valid (spit_valid),
        .spit_data  (spit_data),
        .spit_dreq  (spit_dreq),
        .spit_idle  (spit_idle),
        .spi_sclk   (spi_sclk),
        .spi_mosi   (spi_mosi)
    );

    tc_pl_bus_spi_tx #(.SPI0_0(16), .CLK_DIV(1)) dut_w (
        .clk        (clk),
        .rst        (rst),
        .spit_valid (v2),
        .spit_data  (d2),
        .spit_dreq  (dreq2),
        .spit_idle  (idle2),
        .spi_sclk   (sclk2),
        .spi_mosi   (mosi2)
    );

    // Clock / cycle count
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitors (sampled mid-cycle)
    always @(negedge clk) begin
        if (spi_sclk && !prev_sclk) begin
            got_bits.push_back(spi_mosi);
            rise_q.push_back(cyc);
        end
        prev_sclk <= spi_sclk;
    end

    always @(negedge clk) begin
        if (sclk2 && !prev_sclk2) begin
            got2_bits.push_back(mosi2);
            rise2_q.push_back(cyc);
        end
        prev_sclk2 <= sclk2;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until accepted; acc = accept edge index.
    task automatic send(input logic [7:0] d, output int acc);
        acc = -1;
        spit_valid = 1'b1;
        spit_data  = d;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (spit_dreq) begin
                @(posedge clk);
                #1;
                acc = cyc;
                break;
            end
        end
        spit_valid = 1'b0;
        chk("accept_timeout", (acc >= 0), 1'b1);
    endtask

    task automatic wait_idle(output int when);
        when = -1;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (spit_idle) begin
                when = cyc;
                break;
            end
        end
        chk("idle_timeout", spit_idle, 1'b1);
    endtask

    // Reassemble captured bits into bytes and compare with the expected queue.
    task automatic check_stream(input string tag);
        logic [7:0] b;
        chk({tag, " bit_count"}, got_bits.size(), exp_q.size() * 8);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (got_bits.size() >= 8 * (i + 1)) begin
                b = '0;
                for (int j = 0; j < 8; j++) b = {b[6:0], got_bits[8*i+j]};
                chk({tag, " byte"}, b, exp_q[i]);
            end
        end
    endtask

    task automatic clear_logs();
        got_bits.delete();
        rise_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int a0, a1, a2, when, gaps_bad, acc2, idle2_at;
        logic [7:0]  rb;
        logic [15:0] wexp;

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst dreq", spit_dreq, 1'b0);
        chk("rst idle", spit_idle, 1'b1);
        chk("rst sclk", spi_sclk, 1'b0);
        chk("rst mosi", spi_mosi, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst dreq", spit_dreq, 1'b1);
        chk("post_rst idle", spit_idle, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        chk("quiet edges", rise_q.size(), 0);
        chk("quiet idle", spit_idle, 1'b1);

        // Single byte 0xA5: exact timing
        clear_logs();
        send(8'hA5, a0);
        exp_q.push_back(8'hA5);
        chk("a5 accept idle", spit_idle, 1'b0);
        @(posedge clk);
        #1;
        chk("a5 c1 dreq", spit_dreq, 1'b1);
        chk("a5 c1 idle", spit_idle, 1'b0);
        chk("a5 c1 sclk", spi_sclk, 1'b0);
        chk("a5 c1 mosi", spi_mosi, 1'b1);
        wait_idle(when);
        chk("a5 idle cycle", when, a0 + 65);
        chk("a5 sclk end", spi_sclk, 1'b0);
        chk("a5 mosi end", spi_mosi, 1'b0);
        chk("a5 rise count", rise_q.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < rise_q.size()) chk("a5 rise cycle", rise_q[k], a0 + 5 + 8 * k);
        end
        check_stream("a5");

        // Three bytes back-to-back
        clear_logs();
        send(8'h00, a0);
        exp_q.push_back(8'h00);
        send(8'hFF, a1);
        exp_q.push_back(8'hFF);
        chk("b2b dreq while full", spit_dreq, 1'b0);
        send(8'h3C, a2);
        exp_q.push_back(8'h3C);
        chk("b2b third waits", (a2 > a0 + 60), 1'b1);
        wait_idle(when);
        chk("b2b rise count", rise_q.size(), 24);
        if (rise_q.size() > 0) chk("b2b first rise", rise_q[0], a0 + 5);
        gaps_bad = 0;
        for (int k = 1; k < rise_q.size(); k++) begin
            if (rise_q[k] - rise_q[k-1] != 8) gaps_bad++;
        end
        chk("b2b contiguous", gaps_bad, 0);
        chk("b2b idle cycle", when, a0 + 1 + 3 * 64);
        check_stream("b2b");

        // Valid while dreq low must be ignored
        clear_logs();
        send(8'h96, a0);
        exp_q.push_back(8'h96);
        send(8'h4B, a1);
        exp_q.push_back(8'h4B);
        spit_valid = 1'b1;
        spit_data  = 8'h11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("ignored dreq", spit_dreq, 1'b0);
        end
        @(posedge clk);
        #1;
        spit_valid = 1'b0;
        wait_idle(when);
        check_stream("ignored");

        // Randomized traffic with random gaps
        clear_logs();
        for (int i = 0; i < 6; i++) begin
            rb = 8'($urandom_range(0, 255));
            repeat ($urandom_range(0, 90)) @(posedge clk);
            #1;
            send(rb, a0);
            exp_q.push_back(rb);
        end
        wait_idle(when);
        check_stream("rand");

        // Reset mid-byte with a second byte buffered
        clear_logs();
        send(8'hC3, a0);
        send(8'h5A, a1);
        while (cyc < a0 + 30) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        chk("midrst sclk", spi_sclk, 1'b0);
        chk("midrst mosi", spi_mosi, 1'b0);
        chk("midrst idle", spit_idle, 1'b1);
        chk("midrst dreq", spit_dreq, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_logs();
        repeat (200) @(posedge clk);
        #1;
        chk("after rst edges", rise_q.size(), 0);
        chk("after rst idle", spit_idle, 1'b1);
        chk("after rst dreq", spit_dreq, 1'b1);
        send(8'h69, a0);
        exp_q.push_back(8'h69);
        wait_idle(when);
        check_stream("recover");

        // Wide instance: CLK_DIV=1, 16-bit word 0x8001
        got2_bits.delete();
        rise2_q.delete();
        wexp = 16'h8001;
        acc2 = -1;
        v2 = 1'b1;
        d2 = wexp;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dreq2) begin
                @(posedge clk);
                #1;
                acc2 = cyc;
                break;
            end
        end
        v2 = 1'b0;
        chk("w accepted", (acc2 >= 0), 1'b1);
        idle2_at = -1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (idle2) begin
                idle2_at = cyc;
                break;
            end
        end
        chk("w idle cycle", idle2_at, acc2 + 33);
        chk("w rise count", rise2_q.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < rise2_q.size()) begin
                chk("w rise cycle", rise2_q[k], acc2 + 2 + 2 * k);
                chk("w bit", got2_bits[k], wexp[15-k]);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tc_pl_bus_spi_tx.md
# tc_pl_bus_spi_tx

SPI master serializer directly downstream of the PL bus transmitter. It accepts parallel bytes over the `spit_*` handshake, buffers one byte ahead of the shift register, and shifts MSB-first onto `spi_sclk`/`spi_mosi` in SPI mode 0 (CPOL=0, CPHA=0). Back-to-back bytes are sent with no SCLK gap. Chip select is not handled here; it is driven by the upstream `tx_sel` path.

## Interface
- `SPI0_0`, default 8: byte width in bits.
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `spit_valid`  in  1  upstream byte valid.
- `spit_data`  in  SPI0_0  upstream byte.
- `spit_dreq`  out  1  ready to accept; a byte transfers on a cycle with `spit_valid && spit_dreq`.
- `spit_idle`  out  1  nothing buffered and nothing shifting.
- `spi_sclk`  out  1  SPI clock, idles low.
- `spi_mosi`  out  1  serial data, MSB first.

## Operation
- Reset values: `spit_dreq`=0 while `rst`=0 and 1 from the first clock after release; `spit_idle`=1; `spi_sclk`=0; `spi_mosi`=0.
- Reset is asynchronous: asserting `rst` mid-byte aborts the byte immediately. The buffered byte is discarded.
- Holding register plus `hold_full` flag:
  - `spit_dreq` = `!hold_full`.
  - An accept sets `hold_full`.
  - `spit_valid` while `spit_dreq`=0 is ignored; upstream must hold.
- FSM states:
  - IDLE → SHIFT when `hold_full`. The hold register moves to the shift register, `hold_full` clears, and `spi_mosi` takes the MSB.
  - SHIFT: the divider counts 0..CLK_DIV-1. At each terminal count `spi_sclk` toggles.
    - On each falling edge, the shift register advances and `spi_mosi` takes the next bit.
    - The bit counter decrements on each rising edge.
  - At the final falling edge of a byte, one of two things happens:
    - If `hold_full`=1, the next byte loads in the same cycle, its MSB drives `spi_mosi`, and the FSM stays in SHIFT with no gap.
    - Otherwise the FSM returns to IDLE and `spi_mosi` returns to 0.
- `spit_idle` = (state==IDLE) && !`hold_full`, registered.
- Simultaneous accept and reload in the same cycle is legal. The hold register is freed by the reload and refilled by the accept, so `spit_dreq` stays 0 for at most that cycle.
- Counter widths:
  - Divider: max($clog2(CLK_DIV),1) bits.
  - Bit counter: $clog2(SPI0_0+1) bits.
  - Both counters wrap only through explicit reload, never by overflow.

## Timing
- Byte period is 2·CLK_DIV·SPI0_0 cycles (64 at defaults).
- Accept in IDLE at cycle 0:
  - Cycle 1: SHIFT entered, MSB on `spi_mosi`, `spi_sclk`=0, `spit_idle`=0, `spit_dreq`=1.
  - Rising edges at cycles 1+CLK_DIV+2k·CLK_DIV for k=0..SPI0_0-1 (5, 13, …, 61).
  - Falling edges CLK_DIV cycles later (9, …, 65).
- Single byte: `spi_sclk` low and `spit_idle`=1 from cycle 1+2·CLK_DIV·SPI0_0 (cycle 65).
- `spi_mosi` is stable for the full CLK_DIV cycles before and after each rising edge.
- All outputs are registered. Latency from accept to first SCLK rising edge is 1+CLK_DIV cycles.
- CLK_DIV=1 gives SCLK = clk/2.

## Structure
- Shared package `tc_pl_bus_pkg` holds:
  - FSM state encoding (IDLE=1'b0, SHIFT=1'b1).
  - SPI mode constants (CPOL=0, CPHA=0), kept for future mode extension.
- Sub-module `tc_pl_bus_spi_clkgen`:
  - Parameter CLK_DIV; input `run`.
  - Outputs `sclk` plus one-cycle `rise_stb`/`fall_stb` strobes.
  - When `run`=0, it resets its counter and holds `sclk`=0.
- The top level holds the FSM, hold register, shift register and bit counter.

## Test plan
- Reset release with no traffic → `spit_dreq`=1, `spit_idle`=1, `spi_sclk`=0, `spi_mosi`=0; no SCLK edges for 200 cycles.
- Single byte 0xA5 at defaults → 8 SCLK rising edges at cycles 5..61. Sampled MOSI is 1,0,1,0,0,1,0,1. `spit_idle` rises at cycle 65.
- Three bytes 0x00, 0xFF, 0x3C offered back-to-back with `spit_valid` held → 24 contiguous SCLK periods with no gap and correct bit stream. `spit_dreq` deasserts while the hold register is full.
- `spit_valid` asserted while `spit_dreq`=0 with data 0x11, then dropped → 0x11 never appears on MOSI.
- `rst` asserted at cycle 30 of byte 0xC3 with a second byte buffered → outputs go to reset values immediately. After release, no SCLK activity until a new byte is offered.
- CLK_DIV=1, SPI0_0=16, data 0x8001 → 32-cycle byte, SCLK=clk/2, MOSI 1, fourteen 0s, 1.
